// File: rtl/nes_mem_pkg.sv
// Shared CPU memory-map constants and the sprite DMA state encoding.
// The helper builds the source address with no carry from idx into page.
package nes_mem_pkg;

  localparam logic [15:0] REG_OAMADDR = 16'h2003;
  localparam logic [15:0] REG_OAMDATA = 16'h2004;
  localparam logic [15:0] REG_OAMDMA  = 16'h4014;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHalt  = 3'd1,
    StRead  = 3'd2,
    StWrite = 3'd3,
    StDone  = 3'd4
  } dma_state_e;

  // Page and index are concatenated, so page FF stays inside FF00..FFFF.
  function automatic logic [15:0] dma_src_addr(input logic [7:0] page, input logic [7:0] idx);
    return {page, idx};
  endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: halts the CPU and replays read/write pairs on the mem_decode port,
// copying one CPU page into SPRAM through the OAMDATA register; otherwise a bus pass-through.
module oam_dma_ctrl
  import nes_mem_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR    = REG_OAMDMA,
  parameter logic [15:0] SPRAM_DATA_ADDR = REG_OAMDATA,
  parameter int unsigned XFER_LEN        = 256,
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic        cpu_read_en,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_rdy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  input  logic [7:0]  mem_data_out,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);
  localparam logic [1:0] LAST_LAT = 2'(READ_LATENCY);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] lat_q, lat_d;
  logic [7:0] byte_q, byte_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      lat_q   <= 2'd0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    lat_d        = lat_q;
    byte_d       = byte_q;
    mem_addr     = 16'h0000;
    mem_data_in  = 8'h00;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    cpu_rdy      = 1'b0;
    dma_done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The trigger write itself still reaches mem_decode.
        mem_addr     = cpu_addr;
        mem_data_in  = cpu_data_in;
        mem_write_en = cpu_write_en;
        mem_read_en  = cpu_read_en;
        cpu_rdy      = 1'b1;
        if (cpu_write_en && (cpu_addr == DMA_REG_ADDR)) begin
          page_d  = cpu_data_in;
          idx_d   = 8'h00;
          lat_d   = 2'd0;
          state_d = StHalt;
        end
      end
      StHalt: begin
        lat_d   = 2'd0;
        state_d = StRead;
      end
      StRead: begin
        mem_addr    = dma_src_addr(page_q, idx_q);
        mem_read_en = (lat_q == 2'd0);
        if (lat_q == LAST_LAT) begin
          byte_d  = mem_data_out;
          lat_d   = 2'd0;
          state_d = StWrite;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StWrite: begin
        mem_addr     = SPRAM_DATA_ADDR;
        mem_data_in  = byte_q;
        mem_write_en = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRead;
        end
      end
      StDone: begin
        dma_done = 1'b1;
        cpu_rdy  = 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dma_busy     = (state_q != StIdle);
  assign cpu_data_out = mem_data_out;

endmodule
